sm_occupancy_tracker: RTL and testbench

Sits directly downstream of the concurrent kernel dispatcher and closes its loop. It consumes per-SM workgroup (WG) dispatch pulses and WG completion pulses, and tracks per-SM occupancy: WG count, registers and shared memory. From that it produces the registered sm_free_slot vector that the dispatcher samples. It also reports sticky over/underflow errors and an all-idle indication for drain/context-switch logic.

---
 rtl/gpu_dispatch_pkg.sv | 50 +++++
 rtl/sm_occupancy_tracker_if.sv | 35 +++
 rtl/sm_occ_slot.sv | 92 +++++++++
 rtl/sm_occupancy_tracker.sv | 85 ++++++++
 tb/tb_sm_occupancy_tracker.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_dispatch_pkg.sv
// Constants, types and helpers shared by the GPU dispatcher and the SM occupancy tracker.
// Limits here are the defaults both sides agree on; modules may override them by parameter.
package gpu_dispatch_pkg;

    localparam int NUM_SMS_DEFAULT       = 8;
    localparam int MAX_WG_PER_SM_DEFAULT = 16;
    localparam int REGS_PER_SM_DEFAULT   = 65536;
    localparam int SMEM_PER_SM_DEFAULT   = 49152;
    localparam int LOOKAHEAD_DEFAULT     = 2;

    localparam int RES_W = 16;  // per-lane resource width
    localparam int CNT_W = 17;  // resource counter width
    localparam int CMP_W = 20;  // headroom for next-state and lookahead compares

    function automatic int cnt_width(input int max_cnt);
        return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
    endfunction

    localparam int WG_WIDTH = cnt_width(MAX_WG_PER_SM_DEFAULT);

    typedef struct packed {
        logic [CMP_W-1:0] value;
        logic             over;
        logic             under;
    } step_t;

    // Net counter update: negative results clamp to 0, results above limit saturate.
    function automatic step_t occ_step(input logic [CMP_W-1:0] cur,
                                       input logic [CMP_W-1:0] add,
                                       input logic [CMP_W-1:0] sub,
                                       input logic [CMP_W-1:0] limit);
        step_t            r;
        logic [CMP_W-1:0] sum;
        sum     = cur + add;
        r.over  = 1'b0;
        r.under = 1'b0;
        if (sum < sub) begin
            r.value = '0;
            r.under = 1'b1;
        end else begin
            r.value = sum - sub;
            if (r.value > limit) begin
                r.value = limit;
                r.over  = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sm_occupancy_tracker_if.sv
// Dispatcher <-> occupancy tracker bus: WG dispatch/done event lanes in, per-SM status out.
// Master is the dispatcher side, slave is the tracker.
interface sm_occupancy_tracker_if #(
    parameter int NUM_SMS = gpu_dispatch_pkg::NUM_SMS_DEFAULT
);
    import gpu_dispatch_pkg::*;

    // There is no ready: dispatch_valid[s] and wg_done[s] are single-cycle event pulses,
    // each worth exactly one WG, and their lane data is only meaningful in that cycle.
    logic [RES_W-1:0]         req_regs;
    logic [RES_W-1:0]         req_smem;
    logic [NUM_SMS-1:0]       dispatch_valid;
    logic [NUM_SMS*RES_W-1:0] dispatch_regs;
    logic [NUM_SMS*RES_W-1:0] dispatch_smem;
    logic [NUM_SMS-1:0]       wg_done;
    logic [NUM_SMS*RES_W-1:0] done_regs;
    logic [NUM_SMS*RES_W-1:0] done_smem;
    logic [NUM_SMS-1:0]       sm_free_slot;
    logic                     all_idle;
    logic [NUM_SMS-1:0]       err_overflow;
    logic [NUM_SMS-1:0]       err_underflow;

    modport master (
        output req_regs, req_smem, dispatch_valid, dispatch_regs, dispatch_smem,
        output wg_done, done_regs, done_smem,
        input  sm_free_slot, all_idle, err_overflow, err_underflow
    );

    modport slave (
        input  req_regs, req_smem, dispatch_valid, dispatch_regs, dispatch_smem,
        input  wg_done, done_regs, done_smem,
        output sm_free_slot, all_idle, err_overflow, err_underflow
    );

endinterface

// File: rtl/sm_occ_slot.sv
// One SM's occupancy: WG count, register and shared-memory usage, sticky error flags
// and the registered free-slot decision computed on next-state values.
module sm_occ_slot
    import gpu_dispatch_pkg::*;
#(
    parameter int MAX_WG_PER_SM = MAX_WG_PER_SM_DEFAULT,
    parameter int REGS_PER_SM   = REGS_PER_SM_DEFAULT,
    parameter int SMEM_PER_SM   = SMEM_PER_SM_DEFAULT,
    parameter int LOOKAHEAD     = LOOKAHEAD_DEFAULT,
    parameter int WG_W          = cnt_width(MAX_WG_PER_SM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RES_W-1:0] req_regs,
    input  logic [RES_W-1:0] req_smem,
    input  logic             dispatch_valid,
    input  logic [RES_W-1:0] dispatch_regs,
    input  logic [RES_W-1:0] dispatch_smem,
    input  logic             wg_done,
    input  logic [RES_W-1:0] done_regs,
    input  logic [RES_W-1:0] done_smem,
    output logic             free_slot,
    output logic             err_overflow,
    output logic             err_underflow,
    output logic [WG_W-1:0]  wg_cnt_next
);

    localparam logic [CMP_W-1:0] WG_LIMIT   = CMP_W'(MAX_WG_PER_SM);
    localparam logic [CMP_W-1:0] REGS_LIMIT = CMP_W'(REGS_PER_SM);
    localparam logic [CMP_W-1:0] SMEM_LIMIT = CMP_W'(SMEM_PER_SM);
    localparam logic [CMP_W-1:0] LA         = CMP_W'(LOOKAHEAD);

    logic [WG_W-1:0]  wg_cnt;
    logic [CNT_W-1:0] regs_used;
    logic [CNT_W-1:0] smem_used;

    step_t            wg_step;
    step_t            regs_step;
    step_t            smem_step;
    logic [CMP_W-1:0] wg_w;
    logic [CMP_W-1:0] regs_w;
    logic [CMP_W-1:0] smem_w;
    logic             hold_all;
    logic             ovf_any;
    logic             unf_any;
    logic             fit;

    always_comb begin
        wg_step   = occ_step(CMP_W'(wg_cnt), CMP_W'(dispatch_valid), CMP_W'(wg_done), WG_LIMIT);
        regs_step = occ_step(CMP_W'(regs_used),
                             dispatch_valid ? CMP_W'(dispatch_regs) : '0,
                             wg_done ? CMP_W'(done_regs) : '0, REGS_LIMIT);
        smem_step = occ_step(CMP_W'(smem_used),
                             dispatch_valid ? CMP_W'(dispatch_smem) : '0,
                             wg_done ? CMP_W'(done_smem) : '0, SMEM_LIMIT);

        // A done with nothing resident is bogus: keep every counter as it was.
        hold_all = wg_done && !dispatch_valid && (wg_cnt == '0);
        wg_w     = hold_all ? CMP_W'(wg_cnt)    : wg_step.value;
        regs_w   = hold_all ? CMP_W'(regs_used) : regs_step.value;
        smem_w   = hold_all ? CMP_W'(smem_used) : smem_step.value;

        ovf_any  = wg_step.over | regs_step.over | smem_step.over;
        unf_any  = hold_all | wg_step.under | regs_step.under | smem_step.under;

        fit = (wg_w + LA <= WG_LIMIT)
           && (regs_w + LA * CMP_W'(req_regs) <= REGS_LIMIT)
           && (smem_w + LA * CMP_W'(req_smem) <= SMEM_LIMIT);
    end

    assign wg_cnt_next = wg_w[WG_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wg_cnt        <= '0;
            regs_used     <= '0;
            smem_used     <= '0;
            free_slot     <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            wg_cnt        <= wg_w[WG_W-1:0];
            regs_used     <= regs_w[CNT_W-1:0];
            smem_used     <= smem_w[CNT_W-1:0];
            // The WG issued this cycle is not yet visible upstream, so back off one cycle.
            free_slot     <= fit && !dispatch_valid;
            err_overflow  <= err_overflow | ovf_any;
            err_underflow <= err_underflow | unf_any;
        end
    end

endmodule

// File: rtl/sm_occupancy_tracker.sv
// Per-SM occupancy tracker closing the dispatcher loop; one sm_occ_slot per SM plus all_idle.
// Define OCC_STATS_EN to add the stats_clr input and occ_peak / wg_total statistics outputs.
module sm_occupancy_tracker
    import gpu_dispatch_pkg::*;
#(
    parameter int NUM_SMS       = NUM_SMS_DEFAULT,
    parameter int MAX_WG_PER_SM = MAX_WG_PER_SM_DEFAULT,
    parameter int REGS_PER_SM   = REGS_PER_SM_DEFAULT,
    parameter int SMEM_PER_SM   = SMEM_PER_SM_DEFAULT,
    parameter int LOOKAHEAD     = LOOKAHEAD_DEFAULT,
    localparam int WG_W         = cnt_width(MAX_WG_PER_SM)
) (
    input  logic                      clk,
    input  logic                      rst,
    sm_occupancy_tracker_if.slave     bus
`ifdef OCC_STATS_EN
    ,
    input  logic                      stats_clr,
    output logic [NUM_SMS*WG_W-1:0]   occ_peak,
    output logic [31:0]               wg_total
`endif
);

    logic [NUM_SMS*WG_W-1:0] wg_next_flat;
    logic [NUM_SMS-1:0]      wg_zero;

    for (genvar s = 0; s < NUM_SMS; s++) begin : g_slot
        sm_occ_slot #(
            .MAX_WG_PER_SM (MAX_WG_PER_SM),
            .REGS_PER_SM   (REGS_PER_SM),
            .SMEM_PER_SM   (SMEM_PER_SM),
            .LOOKAHEAD     (LOOKAHEAD),
            .WG_W          (WG_W)
        ) u_slot (
            .clk            (clk),
            .rst            (rst),
            .req_regs       (bus.req_regs),
            .req_smem       (bus.req_smem),
            .dispatch_valid (bus.dispatch_valid[s]),
            .dispatch_regs  (bus.dispatch_regs[s*RES_W +: RES_W]),
            .dispatch_smem  (bus.dispatch_smem[s*RES_W +: RES_W]),
            .wg_done        (bus.wg_done[s]),
            .done_regs      (bus.done_regs[s*RES_W +: RES_W]),
            .done_smem      (bus.done_smem[s*RES_W +: RES_W]),
            .free_slot      (bus.sm_free_slot[s]),
            .err_overflow   (bus.err_overflow[s]),
            .err_underflow  (bus.err_underflow[s]),
            .wg_cnt_next    (wg_next_flat[s*WG_W +: WG_W])
        );

        assign wg_zero[s] = (wg_next_flat[s*WG_W +: WG_W] == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.all_idle <= 1'b1;
        end else begin
            bus.all_idle <= &wg_zero;
        end
    end

`ifdef OCC_STATS_EN
    logic [31:0] dispatch_count;

    always_comb begin
        dispatch_count = 32'($countones(bus.dispatch_valid));
    end

    // Clear wins over any same-cycle dispatch or new high-water mark.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            occ_peak <= '0;
            wg_total <= '0;
        end else begin
            wg_total <= wg_total + dispatch_count;
            for (int s = 0; s < NUM_SMS; s++) begin
                if (wg_next_flat[s*WG_W +: WG_W] > occ_peak[s*WG_W +: WG_W]) begin
                    occ_peak[s*WG_W +: WG_W] <= wg_next_flat[s*WG_W +: WG_W];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sm_occupancy_tracker.sv
// Bench for sm_occupancy_tracker: vector table through a scoreboard queue, then short
// hand-written sequences for reset-cycle behaviour and (with OCC_STATS_EN) statistics.
module tb_sm_occupancy_tracker;
    import gpu_dispatch_pkg::*;

    localparam int N     = 8;
    localparam int WG_W  = cnt_width(16);
    localparam int EXP_W = 3 * N + 1;

    typedef struct {
        logic        rst;
        int          sm;
        logic        disp;
        logic        done;
        logic [15:0] regs;
        logic [15:0] smem;
        logic [15:0] req_regs;
        logic [15:0] req_smem;
        logic [7:0]  free;
        logic        idle;
        logic [7:0]  ovf;
        logic [7:0]  unf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sm_occupancy_tracker_if #(.NUM_SMS(N)) bus ();

`ifdef OCC_STATS_EN
    logic                 stats_clr = 1'b0;
    logic [N*WG_W-1:0]    occ_peak;
    logic [31:0]          wg_total;
`endif

    sm_occupancy_tracker dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef OCC_STATS_EN
        ,
        .stats_clr (stats_clr),
        .occ_peak  (occ_peak),
        .wg_total  (wg_total)
`endif
    );

    vec_t             vecs[$];
    string            tags[$];
    logic [EXP_W-1:0] exp_q[$];
    int               checks = 0;
    int               passed = 0;

    function automatic vec_t mk(input logic r, input int sm, input logic d, input logic dn,
                                input int regs, input int smem, input int rq_r, input int rq_s,
                                input logic [7:0] free, input logic idle,
                                input logic [7:0] ovf, input logic [7:0] unf);
        vec_t v;
        v.rst      = r;
        v.sm       = sm;
        v.disp     = d;
        v.done     = dn;
        v.regs     = 16'(regs);
        v.smem     = 16'(smem);
        v.req_regs = 16'(rq_r);
        v.req_smem = 16'(rq_s);
        v.free     = free;
        v.idle     = idle;
        v.ovf      = ovf;
        v.unf      = unf;
        return v;
    endfunction

    function automatic void add(input string tag, input vec_t v);
        vecs.push_back(v);
        tags.push_back(tag);
    endfunction

    task automatic drive(input vec_t v);
        rst                = v.rst;
        bus.req_regs       = v.req_regs;
        bus.req_smem       = v.req_smem;
        bus.dispatch_valid = '0;
        bus.dispatch_regs  = '0;
        bus.dispatch_smem  = '0;
        bus.wg_done        = '0;
        bus.done_regs      = '0;
        bus.done_smem      = '0;
        if (v.disp) begin
            bus.dispatch_valid[v.sm]         = 1'b1;
            bus.dispatch_regs[v.sm*16 +: 16] = v.regs;
            bus.dispatch_smem[v.sm*16 +: 16] = v.smem;
        end
        if (v.done) begin
            bus.wg_done[v.sm]            = 1'b1;
            bus.done_regs[v.sm*16 +: 16] = v.regs;
            bus.done_smem[v.sm*16 +: 16] = v.smem;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [EXP_W-1:0] exp_v;
        logic [EXP_W-1:0] act_v;
        drive(v);
        exp_q.push_back({v.free, v.idle, v.ovf, v.unf});
        @(posedge clk);
        #1;
        act_v = {bus.sm_free_slot, bus.all_idle, bus.err_overflow, bus.err_underflow};
        exp_v = exp_q.pop_front();
        checks++;
        if (act_v === exp_v) begin
            passed++;
        end else begin
            $display("FAIL %s: got free=%h idle=%b ovf=%h unf=%h, expected free=%h idle=%b ovf=%h unf=%h",
                     tag, act_v[24:17], act_v[16], act_v[15:8], act_v[7:0],
                     exp_v[24:17], exp_v[16], exp_v[15:8], exp_v[7:0]);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act === exp_v) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp_v);
        end
    endtask

    initial begin
        drive(mk(1, 0, 0, 0, 0, 0, 1024, 4096, 8'h00, 1, 8'h00, 8'h00));

        // Reset, then idle with small requirements.
        add("reset_0", mk(1, 0, 0, 0, 0, 0, 1024, 4096, 8'h00, 1, 8'h00, 8'h00));
        add("reset_1", mk(1, 0, 0, 0, 0, 0, 1024, 4096, 8'h00, 1, 8'h00, 8'h00));
        add("idle_after_reset", mk(0, 0, 0, 0, 0, 0, 1024, 4096, 8'hFF, 1, 8'h00, 8'h00));

        // SM0 filled to 57344 regs, then one retire reopens it at exactly 65536.
        for (int k = 1; k <= 7; k++)
            add("sm0_dispatch", mk(0, 0, 1, 0, 8192, 0, 8192, 4096, 8'hFE, 0, 8'h00, 8'h00));
        add("sm0_full", mk(0, 0, 0, 0, 0, 0, 8192, 4096, 8'hFE, 0, 8'h00, 8'h00));
        add("sm0_done_reopen", mk(0, 0, 0, 1, 8192, 0, 8192, 4096, 8'hFF, 0, 8'h00, 8'h00));
        for (int j = 1; j <= 6; j++)
            add("sm0_drain", mk(0, 0, 0, 1, 8192, 0, 8192, 4096, 8'hFF, (j == 6), 8'h00, 8'h00));

        // SM3 same-cycle dispatch+done; req_regs boundary pins regs_used at 4096.
        add("sm3_dispatch", mk(0, 3, 1, 0, 4096, 0, 30720, 4096, 8'hF7, 0, 8'h00, 8'h00));
        add("sm3_disp_and_done", mk(0, 3, 1, 1, 4096, 0, 30720, 4096, 8'hF7, 0, 8'h00, 8'h00));
        add("sm3_fit_exact", mk(0, 0, 0, 0, 0, 0, 30720, 4096, 8'hFF, 0, 8'h00, 8'h00));
        add("sm3_fit_over", mk(0, 0, 0, 0, 0, 0, 30722, 4096, 8'hF7, 0, 8'h00, 8'h00));
        add("sm3_done_idle", mk(0, 3, 0, 1, 4096, 0, 30722, 4096, 8'hFF, 1, 8'h00, 8'h00));

        // SM1 WG-count overflow and saturation at 16.
        for (int k = 1; k <= 17; k++)
            add("sm1_dispatch", mk(0, 1, 1, 0, 0, 0, 1024, 4096, 8'hFD, 0,
                                   (k == 17) ? 8'h02 : 8'h00, 8'h00));
        add("sm1_saturated", mk(0, 0, 0, 0, 0, 0, 1024, 4096, 8'hFD, 0, 8'h02, 8'h00));
        for (int d = 1; d <= 16; d++)
            add("sm1_drain", mk(0, 1, 0, 1, 0, 0, 1024, 4096, (d >= 2) ? 8'hFF : 8'hFD,
                                (d == 16), 8'h02, 8'h00));

        // Underflows: done to an empty SM, and resource release larger than usage.
        add("sm5_done_empty", mk(0, 5, 0, 1, 0, 0, 1024, 4096, 8'hFF, 1, 8'h02, 8'h20));
        add("sm5_sticky", mk(0, 0, 0, 0, 0, 0, 1024, 4096, 8'hFF, 1, 8'h02, 8'h20));
        add("sm6_dispatch", mk(0, 6, 1, 0, 100, 0, 1024, 4096, 8'hBF, 0, 8'h02, 8'h20));
        add("sm6_regs_clamp", mk(0, 6, 0, 1, 200, 0, 1024, 4096, 8'hFF, 1, 8'h02, 8'h60));

        // SM7 shared-memory boundary, overflow saturation, then clamp below zero.
        add("sm7_dispatch", mk(0, 7, 1, 0, 0, 40960, 1024, 4096, 8'h7F, 0, 8'h02, 8'h60));
        add("sm7_smem_exact", mk(0, 0, 0, 0, 0, 0, 1024, 4096, 8'hFF, 0, 8'h02, 8'h60));
        add("sm7_smem_over", mk(0, 0, 0, 0, 0, 0, 1024, 4097, 8'h7F, 0, 8'h02, 8'h60));
        add("sm7_smem_ovf", mk(0, 7, 1, 0, 0, 16384, 1024, 4096, 8'h7F, 0, 8'h82, 8'h60));
        add("sm7_done_limit", mk(0, 7, 0, 1, 0, 49152, 1024, 4096, 8'hFF, 0, 8'h82, 8'h60));
        add("sm7_done_clamp", mk(0, 7, 0, 1, 0, 1, 1024, 4096, 8'hFF, 1, 8'h82, 8'hE0));

        // SM4 register overflow, then reset mid-operation with a dispatch in the reset cycle.
        add("sm4_dispatch_big", mk(0, 4, 1, 0, 65535, 0, 1024, 4096, 8'hEF, 0, 8'h82, 8'hE0));
        add("sm4_regs_ovf", mk(0, 4, 1, 0, 2, 0, 1024, 4096, 8'hEF, 0, 8'h92, 8'hE0));
        add("sm4_full", mk(0, 0, 0, 0, 0, 0, 1024, 4096, 8'hEF, 0, 8'h92, 8'hE0));
        add("mid_reset", mk(1, 2, 1, 0, 100, 0, 1024, 4096, 8'h00, 1, 8'h00, 8'h00));
        add("after_mid_reset", mk(0, 0, 0, 0, 0, 0, 1024, 4096, 8'hFF, 1, 8'h00, 8'h00));

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], tags[i]);

        // Done and dispatch during reset must leave no trace.
        drive(mk(1, 0, 0, 0, 0, 0, 1024, 4096, 8'h00, 1, 8'h00, 8'h00));
        bus.wg_done[5]        = 1'b1;
        bus.dispatch_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_cycle_free", 32'(bus.sm_free_slot), 32'h00);
        check_val("rst_cycle_idle", 32'(bus.all_idle), 32'h1);
        drive(mk(0, 0, 0, 0, 0, 0, 1024, 4096, 8'hFF, 1, 8'h00, 8'h00));
        @(posedge clk);
        #1;
        check_val("post_rst_free", 32'(bus.sm_free_slot), 32'hFF);
        check_val("post_rst_idle", 32'(bus.all_idle), 32'h1);
        check_val("post_rst_unf", 32'(bus.err_underflow), 32'h00);
        check_val("post_rst_ovf", 32'(bus.err_overflow), 32'h00);

`ifdef OCC_STATS_EN
        stats_clr = 1'b1;
        run_vec(mk(0, 0, 0, 0, 0, 0, 1024, 4096, 8'hFF, 1, 8'h00, 8'h00), "stats_clr_idle");
        stats_clr = 1'b0;
        check_val("wg_total_clr", wg_total, 32'd0);
        check_val("occ_peak_clr", 32'(occ_peak), 32'd0);
        for (int k = 1; k <= 5; k++)
            run_vec(mk(0, 2, 1, 0, 0, 0, 1024, 4096, 8'hFB, 0, 8'h00, 8'h00), "sm2_dispatch");
        check_val("occ_peak2_up", 32'(occ_peak[2*WG_W +: WG_W]), 32'd5);
        check_val("wg_total_up", wg_total, 32'd5);
        for (int d = 1; d <= 5; d++)
            run_vec(mk(0, 2, 0, 1, 0, 0, 1024, 4096, 8'hFF, (d == 5), 8'h00, 8'h00), "sm2_done");
        check_val("occ_peak2_hold", 32'(occ_peak[2*WG_W +: WG_W]), 32'd5);
        check_val("occ_peak_others", 32'(occ_peak) & ~(32'h1F << (2*WG_W)), 32'd0);
        check_val("wg_total_hold", wg_total, 32'd5);
        stats_clr = 1'b1;
        run_vec(mk(0, 2, 1, 0, 0, 0, 1024, 4096, 8'hFB, 0, 8'h00, 8'h00), "stats_clr_prio");
        stats_clr = 1'b0;
        check_val("wg_total_clr_prio", wg_total, 32'd0);
        check_val("occ_peak_clr_prio", 32'(occ_peak), 32'd0);
        run_vec(mk(0, 0, 0, 0, 0, 0, 1024, 4096, 8'hFF, 0, 8'h00, 8'h00), "stats_resume");
        check_val("occ_peak2_resume", 32'(occ_peak[2*WG_W +: WG_W]), 32'd1);
        check_val("wg_total_resume", wg_total, 32'd0);
        run_vec(mk(0, 2, 0, 1, 0, 0, 1024, 4096, 8'hFF, 1, 8'h00, 8'h00), "sm2_final_done");
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
